// File: rtl/vga_balayage.sv
// vga_balayage: VGA raster timing, palette-to-RGB mapping and gravity pulse
// generation for the falling-brick game.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset (0 = reset)
//   Couleur      5-bit palette code for the current hpos/vpos (from draw logic)
//   test_pattern colour-bar select (only with VGA_BALAYAGE_TEST_PATTERN_EN)
//   hpos, vpos   11-bit raster counters, 0 at start of hsync / vsync
//   hsync, vsync active-low sync, registered one clk behind hpos/vpos
//   red/green/blue  3-3-2 pixel colour, registered, zero outside active window
//   pulse        one-clk gravity tick every FRAMES_PER_PULSE frames
//
// Optional feature macro: VGA_BALAYAGE_TEST_PATTERN_EN adds the test_pattern
// input and an 8-bar colour pattern across the active window.
module vga_balayage #(
    parameter int unsigned PIXEL_DIV        = 2,
    parameter int unsigned H_TOTAL          = 800,
    parameter int unsigned H_PULSE          = 96,
    parameter int unsigned H_FRONT          = 16,
    parameter int unsigned H_DISPLAY        = 640,
    parameter int unsigned V_TOTAL          = 521,
    parameter int unsigned V_PULSE          = 2,
    parameter int unsigned V_FRONT          = 10,
    parameter int unsigned V_DISPLAY        = 480,
    parameter int unsigned FRAMES_PER_PULSE = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Couleur,
`ifdef VGA_BALAYAGE_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    output logic [10:0] hpos,
    output logic [10:0] vpos,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [1:0]  blue,
    output logic        pulse
);

    localparam int unsigned POS_W = 11;
    localparam int unsigned DIV_W = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
    localparam int unsigned FRM_W = (FRAMES_PER_PULSE > 1) ? $clog2(FRAMES_PER_PULSE) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(PIXEL_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST    = FRM_W'(FRAMES_PER_PULSE - 1);
    localparam logic [POS_W-1:0] H_LAST      = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST      = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_SYNC_END  = POS_W'(H_PULSE);
    localparam logic [POS_W-1:0] V_SYNC_END  = POS_W'(V_PULSE);
    localparam logic [POS_W-1:0] H_ACT_START = POS_W'(H_PULSE + H_FRONT);
    localparam logic [POS_W-1:0] H_ACT_END   = POS_W'(H_PULSE + H_FRONT + H_DISPLAY);
    localparam logic [POS_W-1:0] V_ACT_START = POS_W'(V_PULSE + V_FRONT);
    localparam logic [POS_W-1:0] V_ACT_END   = POS_W'(V_PULSE + V_FRONT + V_DISPLAY);

`ifdef VGA_BALAYAGE_TEST_PATTERN_EN
    localparam logic [POS_W-1:0] BAR_W = (H_DISPLAY >= 8) ? POS_W'(H_DISPLAY / 8) : POS_W'(1);
`endif

    logic [DIV_W-1:0] div_q,   div_d;
    logic [POS_W-1:0] hpos_q,  hpos_d;
    logic [POS_W-1:0] vpos_q,  vpos_d;
    logic [FRM_W-1:0] frame_q, frame_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [7:0]       rgb_q,   rgb_d;
    logic             pulse_q, pulse_d;

    logic             pix_en_c;
    logic             line_end_c;
    logic             frame_end_c;
    logic             active_c;
    logic [7:0]       pixel_c;

    // Palette code to packed 3-3-2 colour.
    function automatic logic [7:0] palette(input logic [4:0] code);
        case (code)
            5'd0:    palette = 8'b111_111_11;
            5'd18:   palette = 8'b111_000_00;
            5'd9:    palette = 8'b000_111_00;
            5'd3:    palette = 8'b000_000_11;
            5'd24:   palette = 8'b101_010_00;
            default: palette = 8'b000_000_00;
        endcase
    endfunction

`ifdef VGA_BALAYAGE_TEST_PATTERN_EN
    // Colour bars left to right across the active window.
    function automatic logic [7:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 8'b111_111_11;
            3'd1:    bar_colour = 8'b111_000_00;
            3'd2:    bar_colour = 8'b000_111_00;
            3'd3:    bar_colour = 8'b000_000_11;
            3'd4:    bar_colour = 8'b101_010_00;
            3'd5:    bar_colour = 8'b111_111_00;
            3'd6:    bar_colour = 8'b000_111_11;
            default: bar_colour = 8'b000_000_00;
        endcase
    endfunction

    logic [POS_W-1:0] bar_q_c;
    assign bar_q_c = (hpos_q - H_ACT_START) / BAR_W;
    assign pixel_c = test_pattern ? bar_colour(3'(bar_q_c)) : palette(Couleur);
`else
    assign pixel_c = palette(Couleur);
`endif

    // Pixel enable: last divider phase; with PIXEL_DIV=1 the divider sits at 0 = last.
    assign pix_en_c    = (div_q == DIV_LAST);
    assign line_end_c  = pix_en_c && (hpos_q == H_LAST);
    assign frame_end_c = line_end_c && (vpos_q == V_LAST);
    assign active_c    = (hpos_q >= H_ACT_START) && (hpos_q < H_ACT_END) &&
                         (vpos_q >= V_ACT_START) && (vpos_q < V_ACT_END);

    // Next-state for counters, sync, colour and pulse.
    always_comb begin
        div_d   = div_q;
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        frame_d = frame_q;
        pulse_d = 1'b0;

        div_d = pix_en_c ? '0 : div_q + DIV_W'(1);

        if (pix_en_c) begin
            hpos_d = line_end_c ? '0 : hpos_q + POS_W'(1);
        end
        if (line_end_c) begin
            vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + POS_W'(1);
        end

        // Frame counter wraps on the pulse frame so the tick lands on the next clk.
        if (frame_end_c) begin
            if (frame_q == FRM_LAST) begin
                frame_d = '0;
                pulse_d = 1'b1;
            end else begin
                frame_d = frame_q + FRM_W'(1);
            end
        end

        // Sync and colour sample the current counters, landing one clk later.
        hsync_d = !(hpos_q < H_SYNC_END);
        vsync_d = !(vpos_q < V_SYNC_END);
        rgb_d   = active_c ? pixel_c : 8'h00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            hpos_q  <= '0;
            vpos_q  <= '0;
            frame_q <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 8'h00;
            pulse_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            frame_q <= frame_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
            pulse_q <= pulse_d;
        end
    end

    assign hpos  = hpos_q;
    assign vpos  = vpos_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign red   = rgb_q[7:5];
    assign green = rgb_q[4:2];
    assign blue  = rgb_q[1:0];
    assign pulse = pulse_q;

endmodule

// File: doc/vga_balayage.md
Name: vga_balayage

Overview:
- Generates VGA raster timing (`hpos`, `vpos`, `hsync`, `vsync`) for the falling-brick game.
- Turns the 5-bit palette code returned by the gravity/draw logic into 8-bit RGB (3-3-2).
- Produces the single-cycle gravity `pulse`, once every N frames.
- Sits between the board VGA connector and the game logic; it drives the pixel coordinates the draw logic consumes.

Parameters:
- PIXEL_DIV, 2, `clk` cycles per pixel (50 MHz -> 25 MHz pixel enable)
- H_TOTAL, 800, pixels per line
- H_PULSE, 96, hsync low width
- H_FRONT, 16, gap between hsync end and active video
- H_DISPLAY, 640, active pixels
- V_TOTAL, 521, lines per frame
- V_PULSE, 2, vsync low width in lines
- V_FRONT, 10, gap between vsync end and active video
- V_DISPLAY, 480, active lines
- FRAMES_PER_PULSE, 30, frames between gravity pulses

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- Couleur  in  5  palette code for the current hpos/vpos (combinational from draw logic)
- hpos  out  11  horizontal count, 0 at start of hsync
- vpos  out  11  vertical count, 0 at start of vsync
- hsync  out  1  active-low
- vsync  out  1  active-low
- red  out  3  pixel red
- green  out  3  pixel green
- blue  out  2  pixel blue
- pulse  out  1  one-clk gravity tick
- (TEST_PATTERN_EN only) test_pattern  in  1  select colour bars

Behaviour:
- Reset (reset=0, async):
  - Clears divider, hpos=0, vpos=0, frame counter=0.
  - hsync=1, vsync=1, RGB=0, pulse=0.
  - Release is synchronous to the next clk edge.
- Pixel enable (pix_en):
  - Divider counts 0..PIXEL_DIV-1; pix_en=1 on the clk where the divider equals PIXEL_DIV-1.
  - PIXEL_DIV=1 gives pix_en permanently high.
- Horizontal counter:
  - On pix_en, hpos increments.
  - At hpos=H_TOTAL-1 it wraps to 0 and vpos increments.
  - At vpos=V_TOTAL-1 with hpos wrap, vpos wraps to 0 (end of frame).
  - Counters hold between pix_en.
- Sync timing:
  - hsync is low for hpos<H_PULSE; vsync is low for vpos<V_PULSE.
  - Both are registered, one clk behind hpos/vpos, so they stay aligned with RGB.
- Active window:
  - H_PULSE+H_FRONT <= hpos < H_PULSE+H_FRONT+H_DISPLAY (112..751).
  - V_PULSE+V_FRONT <= vpos < V_PULSE+V_FRONT+V_DISPLAY (12..491).
  - Outside the window RGB=0 (blanking), regardless of Couleur.
- Palette (RGB registered, 1 clk latency from hpos/vpos/Couleur):
  - 0 -> 7/7/3 white
  - 18 -> 7/0/0 red
  - 9 -> 0/7/0 green
  - 3 -> 0/0/3 blue
  - 24 -> 5/2/0 brown
  - any other code -> 0/0/0
- Gravity pulse:
  - Frame counter increments at each end-of-frame event.
  - When it reaches FRAMES_PER_PULSE-1 at end of frame, it wraps to 0 and pulse=1 for exactly one clk (the clk after the event).
  - pulse=0 at all other times.
  - FRAMES_PER_PULSE=1 gives one pulse per frame.
- Reset mid-frame: all counters restart from 0, so the next pulse comes FRAMES_PER_PULSE full frames after release. No partial pulse.
- Widths: hpos/vpos are 11 bits. Comparisons use unsigned 11-bit arithmetic with constants sized to 11 bits. The frame counter is sized to clog2(FRAMES_PER_PULSE), minimum 1 bit.

Optional Feature:
- Macro `VGA_BALAYAGE_TEST_PATTERN_EN`.
- Defined:
  - Adds the `test_pattern` input.
  - When test_pattern=1, the active-window RGB ignores Couleur and shows 8 vertical bars, each 80 px wide, in order white, red, green, blue, brown, 7/7/0, 0/7/3, 0/0/0.
  - Bar index = (hpos-112)/80.
  - Timing and pulse are unaffected.
- Undefined: the port is absent and RGB always comes from Couleur.

Test Plan:
- Line timing: PIXEL_DIV=2, reset released -> hsync low for 192 clk, line period 1600 clk; hpos goes 799->0 and vpos 0->1 on the same pix_en.
- Frame timing: run one frame -> vsync low for exactly 2 lines (3200 clk); frame period 833600 clk; vpos 520->0 with hpos 799->0.
- Active window and palette: Couleur=18 constant -> RGB=7/0/0 only when hpos 112..751 and vpos 12..491 (one clk later); at hpos=111 and 752, RGB=0. Couleur=5 -> RGB=0 everywhere.
- Gravity pulse: FRAMES_PER_PULSE=3 -> pulse high for exactly 1 clk, first one after the end of frame 3, then every 2500800 clk.
- Reset mid-frame: reset=0 at vpos=200 for 3 clk -> all outputs take reset values immediately; after release hpos/vpos restart at 0 and the first pulse comes after a full FRAMES_PER_PULSE frames.
- Test pattern (macro defined): test_pattern=1, Couleur=9 -> at hpos=200 RGB=7/0/0, at hpos=700 RGB=0/0/0; test_pattern=0 -> 0/7/0.
